dsec: RTL and testbench

DSEC -- requirements
Module: dsec

---
 rtl/dsec.sv | 158 +++++++++++++++
 tb/tb_dsec.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsec.sv
// Single-word keyed scrambler: three loaded keys transform one data word per
// handshake as R = rotl(D ^ K1, K2[5:0]) + K3, with a sticky protocol-error flag.
module dsec #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              key_config,
  input  logic              in_valid,
  input  logic              out_rcvd,
  output logic              rdy,
  output logic [DATA_W-1:0] data_out,
  output logic              error,
  output logic              out_valid
);

  localparam int ROT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] k1;
  logic [DATA_W-1:0] k2;
  logic [DATA_W-1:0] k3;
  logic [1:0]        key_idx;
  logic              keys_loaded;

  logic              key_wr;
  logic              data_acc;
  logic              err_set;

  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] result_p1;

  // Doubling the word and keeping the upper half gives a rotate in which an
  // amount of zero naturally passes the value through unchanged.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v,
                                             input logic [ROT_W-1:0]  amt);
    logic [2*DATA_W-1:0] t;
    t = {v, v} << amt;
    return t[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] encrypt(input logic [DATA_W-1:0] d,
                                                input logic [DATA_W-1:0] ka,
                                                input logic [DATA_W-1:0] kb,
                                                input logic [DATA_W-1:0] kc);
    return rotl(d ^ ka, kb[ROT_W-1:0]) + kc;
  endfunction

  always_comb begin
    state_nxt = state;
    key_wr    = 1'b0;
    data_acc  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (key_config) begin
            if (key_idx == 2'd3) begin
              err_set = 1'b1;
            end else begin
              key_wr = 1'b1;
            end
          end else if (keys_loaded) begin
            data_acc  = 1'b1;
            state_nxt = CALC;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      CALC: begin
        state_nxt = OUT;
        err_set   = in_valid;
      end
      OUT: begin
        if (out_rcvd) begin
          state_nxt = IDLE;
        end
        err_set = in_valid;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k1          <= '0;
      k2          <= '0;
      k3          <= '0;
      key_idx     <= 2'd0;
      keys_loaded <= 1'b0;
      error       <= 1'b0;
    end else begin
      // A data-side cycle restarts the key sequence even without in_valid.
      if (!key_config) begin
        key_idx <= 2'd0;
      end else if (key_wr) begin
        key_idx <= key_idx + 2'd1;
      end
      if (key_wr) begin
        case (key_idx)
          2'd0: begin
            k1          <= data_in;
            keys_loaded <= 1'b0;
          end
          2'd1: k2 <= data_in;
          2'd2: begin
            k3          <= data_in;
            keys_loaded <= 1'b1;
          end
          default: ;
        endcase
      end
      if (err_set) begin
        error <= 1'b1;
      end
    end
  end

  // Stage p0: capture the accepted data word
  always_ff @(posedge clk) begin
    if (data_acc) begin
      data_p0 <= data_in;
    end
  end

  // Stage p1: keys are frozen outside IDLE, so the result is stable in CALC
  assign result_p1 = encrypt(data_p0, k1, k2, k3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (state == CALC) begin
      data_out <= result_p1;
    end
  end

  assign rdy       = (state == IDLE);
  assign out_valid = (state == OUT);

endmodule

// File: tb/tb_dsec.sv
// Bench for dsec: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the key/data/acknowledge rules.
module tb_dsec;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic        key_config;
  logic        in_valid;
  logic        out_rcvd;
  logic        rdy;
  logic [63:0] data_out;
  logic        error;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = waiting, 1 = computing, 2 = result held
  logic [63:0] m_key [3];
  int          m_idx;
  bit          m_loaded;
  bit          m_err;
  logic [63:0] m_d;
  logic [63:0] m_dout;
  int          m_phase;

  dsec dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .key_config (key_config),
    .in_valid   (in_valid),
    .out_rcvd   (out_rcvd),
    .rdy        (rdy),
    .data_out   (data_out),
    .error      (error),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_enc(input logic [63:0] d);
    logic [63:0] x;
    logic [63:0] r;
    logic [5:0]  amt;
    x   = d ^ m_key[0];
    amt = m_key[1][5:0];
    if (amt == 6'd0) r = x;
    else             r = (x << amt) | (x >> (7'd64 - {1'b0, amt}));
    return r + m_key[2];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_key[i] = 64'd0;
    m_idx    = 0;
    m_loaded = 0;
    m_err    = 0;
    m_d      = 64'd0;
    m_dout   = 64'd0;
    m_phase  = 0;
  endtask

  task automatic model_step(input bit iv, input bit kc, input logic [63:0] d, input bit rc);
    case (m_phase)
      0: if (iv) begin
        if (kc) begin
          if (m_idx < 3) begin
            m_key[m_idx] = d;
            if (m_idx == 0) m_loaded = 0;
            if (m_idx == 2) m_loaded = 1;
            m_idx++;
          end else begin
            m_err = 1;
          end
        end else if (m_loaded) begin
          m_d     = d;
          m_phase = 1;
        end else begin
          m_err = 1;
        end
      end
      1: begin
        m_dout  = ref_enc(m_d);
        m_phase = 2;
        if (iv) m_err = 1;
      end
      default: begin
        if (iv) m_err = 1;
        if (rc) m_phase = 0;
      end
    endcase
    if (!kc) m_idx = 0;
  endtask

  task automatic check_model();
    chk("rdy",       64'(rdy),       64'(m_phase == 0));
    chk("out_valid", 64'(out_valid), 64'(m_phase == 2));
    chk("data_out",  data_out,       m_dout);
    chk("error",     64'(error),     64'(m_err));
  endtask

  task automatic cycle(input bit iv, input bit kc, input logic [63:0] d, input bit rc);
    in_valid   = iv;
    key_config = kc;
    data_in    = d;
    out_rcvd   = rc;
    @(posedge clk);
    model_step(iv, kc, d, rc);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    key_config = 1'b0;
    out_rcvd   = 1'b0;
    data_in    = 64'd0;
    rst        = 1'b1;
    #1;
    chk("rst_rdy",       64'(rdy),       64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out",  data_out,       64'd0);
    chk("rst_error",     64'(error),     64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_keys(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    cycle(1, 1, a, 0);
    cycle(1, 1, b, 0);
    cycle(1, 1, c, 0);
    cycle(0, 0, 64'd0, 0);
  endtask

  localparam logic [63:0] K1 = 64'h1111111111111111;
  localparam logic [63:0] K2 = 64'h2222222222222222;
  localparam logic [63:0] K3 = 64'h3333333333333333;
  localparam logic [63:0] R0 = 64'h7777777777777777;

  initial begin
    logic [63:0] rk1, rk2, rk3, rd;
    int          sel;

    // Basic encryption and two-cycle latency
    do_reset();
    load_keys(K1, K2, K3);
    cycle(1, 0, 64'd0, 0);
    chk("accept_no_valid", 64'(out_valid), 64'd0);
    cycle(0, 0, 64'd0, 0);
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("vec0_data",     data_out,       R0);
    chk("vec0_error",    64'(error),     64'd0);
    cycle(0, 0, 64'd0, 1);
    chk("ack_rdy", 64'(rdy), 64'd1);

    cycle(1, 0, K1, 0);
    cycle(0, 0, 64'd0, 0);
    chk("vec1_data", data_out, K3);
    cycle(0, 0, 64'd0, 1);
    chk("vec1_ack_valid", 64'(out_valid), 64'd0);
    chk("vec1_ack_rdy",   64'(rdy),       64'd1);
    chk("retain_data",    data_out,       K3);

    // Zero rotate amount
    do_reset();
    load_keys(64'd0, 64'h40, 64'd0);
    cycle(1, 0, 64'h8000000000000001, 0);
    cycle(0, 0, 64'd0, 0);
    chk("rot0_data", data_out, 64'h8000000000000001);
    cycle(0, 0, 64'd0, 1);

    // Data with no keys loaded
    do_reset();
    cycle(1, 0, 64'h1234, 0);
    chk("nokey_error", 64'(error),     64'd1);
    chk("nokey_valid", 64'(out_valid), 64'd0);
    chk("nokey_rdy",   64'(rdy),       64'd1);

    // Word arriving while a result is held
    do_reset();
    load_keys(K1, K2, K3);
    cycle(1, 0, 64'd0, 0);
    cycle(0, 0, 64'd0, 0);
    cycle(1, 0, 64'hFFFFFFFFFFFFFFFF, 0);
    chk("busy_error", 64'(error),     64'd1);
    chk("busy_data",  data_out,       R0);
    chk("busy_valid", 64'(out_valid), 64'd1);
    cycle(0, 0, 64'd0, 1);
    chk("busy_ack_rdy", 64'(rdy), 64'd1);

    // Acknowledge and a key word on the same edge
    do_reset();
    load_keys(K1, K2, K3);
    cycle(1, 0, 64'd0, 0);
    cycle(0, 0, 64'd0, 0);
    cycle(1, 1, 64'h5555555555555555, 1);
    chk("collide_rdy",   64'(rdy),   64'd1);
    chk("collide_error", 64'(error), 64'd1);
    cycle(1, 0, 64'd0, 0);
    cycle(0, 0, 64'd0, 0);
    chk("collide_keys_kept", data_out, R0);
    cycle(0, 0, 64'd0, 1);

    // Fourth key word overflows
    do_reset();
    cycle(1, 1, K1, 0);
    cycle(1, 1, K2, 0);
    cycle(1, 1, K3, 0);
    cycle(1, 1, 64'hDEADBEEFDEADBEEF, 0);
    chk("ovf_error", 64'(error), 64'd1);
    cycle(1, 0, 64'd0, 0);
    cycle(0, 0, 64'd0, 0);
    chk("ovf_data", data_out, R0);

    // Reset while holding a result
    do_reset();
    load_keys(K1, K2, K3);
    cycle(1, 0, 64'd0, 0);
    cycle(0, 0, 64'd0, 0);
    cycle(1, 0, 64'd1, 0);
    do_reset();
    cycle(1, 0, 64'd0, 0);
    chk("rst_keys_cleared", 64'(error), 64'd1);
    chk("rst_keys_rdy",     64'(rdy),   64'd1);

    // Randomized traffic over freshly keyed epochs
    for (int ep = 0; ep < 50; ep++) begin
      do_reset();
      rk1 = {$urandom, $urandom};
      rk2 = {$urandom, $urandom};
      rk3 = {$urandom, $urandom};
      if (ep % 7 == 0) rk2[5:0] = 6'd0;
      load_keys(rk1, rk2, rk3);
      for (int c = 0; c < 60; c++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0:       rd = 64'd0;
          1:       rd = 64'hFFFFFFFFFFFFFFFF;
          default: rd = {$urandom, $urandom};
        endcase
        cycle($urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, rd,
              $urandom_range(0, 2) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
